ebs_watchdog: RTL and testbench

Heartbeat watchdog that produces the `Watchdog` input of the shutdown-circuit (SDC) latch stage. It monitors a toggle-type heartbeat from the autonomous-system computer and holds `Watchdog` high only while the heartbeat toggles within a bounded period. It latches a trip on heartbeat loss and requires an explicit re-arm, so a single missed window always opens the SDC.

---
 rtl/ebs_watchdog.sv | 146 ++++++++++++++
 tb/tb_ebs_watchdog.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ebs_watchdog.sv
// ebs_watchdog: heartbeat watchdog feeding the SDC Watchdog input.
// The heartbeat is a toggle signal, so every transition counts as one beat.
// Watchdog is high only in RUN. Losing the heartbeat latches TRIPPED, and
// leaving TRIPPED requires an explicit Rearm followed by a fresh arming.
// Optional feature: define EBS_WDG_MIN_PERIOD_CHECK_EN to trip on
// heartbeat edges that arrive closer together than MIN_PERIOD cycles.
module ebs_watchdog #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int MIN_PERIOD     = 10,
  parameter int ARM_EDGES      = 3
) (
  input  logic       Clock,
  input  logic       Power_on_Reset,
  input  logic       Heartbeat,
  input  logic       Rearm,
  output logic       Watchdog,
  output logic       Watchdog_tripped,
  output logic [7:0] Trip_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The arm counter only needs to hold 0..ARM_EDGES-1, because reaching
  // ARM_EDGES moves straight to RUN.
  localparam int AW = (ARM_EDGES > 1) ? $clog2(ARM_EDGES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_EDGES - 1);

  // Reject parameter sets that would make the timing rules meaningless.
  if (TIMEOUT_CYCLES < 4 || ARM_EDGES < 1 || MIN_PERIOD >= TIMEOUT_CYCLES) begin : g_bad_params
    $error("ebs_watchdog: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ARMING  = 2'd0,
    RUN     = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  logic          hb_sync1, hb_sync2, hb_prev;
  logic          hb_edge;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] arm_cnt, arm_cnt_n;
  state_t        state, state_n;
  logic          trip_inc;

  // Synchronize the asynchronous heartbeat and keep its previous value.
  // NOTE: non-blocking assignments make every flop sample the old value of
  // the one before it, so this really is a three-stage shift chain.
  always_ff @(posedge Clock or posedge Power_on_Reset) begin
    if (Power_on_Reset) begin
      hb_sync1 <= 1'b0;
      hb_sync2 <= 1'b0;
      hb_prev  <= 1'b0;
    end else begin
      hb_sync1 <= Heartbeat;
      hb_sync2 <= hb_sync1;
      hb_prev  <= hb_sync2;
    end
  end

  // Any transition of the synchronized heartbeat is one beat.
  assign hb_edge = hb_sync2 ^ hb_prev;

  // Next-state logic: arming, healthy run and the latched trip.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    arm_cnt_n = arm_cnt;
    trip_inc  = 1'b0;
    unique case (state)
      ARMING: begin
        if (cnt == CNT_MAX) begin
          // Too slow to arm: start over. This is never a trip.
          arm_cnt_n = '0;
        end else if (hb_edge) begin
          if (arm_cnt == ARM_LAST) begin
            state_n   = RUN;
            arm_cnt_n = '0;
          end else begin
            arm_cnt_n = arm_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (!hb_edge && cnt == CNT_LAST) begin
          state_n  = TRIPPED;
          trip_inc = 1'b1;
        end
`ifdef EBS_WDG_MIN_PERIOD_CHECK_EN
        // An edge with cnt+1 < MIN_PERIOD means the source is oscillating.
        else if (hb_edge && cnt < CW'(MIN_PERIOD - 1)) begin
          state_n  = TRIPPED;
          trip_inc = 1'b1;
        end
`endif
      end
      TRIPPED: begin
        if (Rearm) begin
          state_n   = ARMING;
          arm_cnt_n = '0;
        end
      end
      default: begin
        state_n   = ARMING;
        arm_cnt_n = '0;
      end
    endcase
  end

  // Cycles since the last beat. Every state entry restarts the count, so
  // each state measures time from its own start.
  always_comb begin
    cnt_n = cnt;
    if (state_n != state || hb_edge) begin
      cnt_n = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_n = cnt + 1'b1;
    end
  end

  // State, counters and registered outputs. The outputs are decoded from the
  // next state, which keeps them aligned with the state register.
  always_ff @(posedge Clock or posedge Power_on_Reset) begin
    if (Power_on_Reset) begin
      state            <= ARMING;
      cnt              <= '0;
      arm_cnt          <= '0;
      Watchdog         <= 1'b0;
      Watchdog_tripped <= 1'b0;
      Trip_count       <= 8'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      arm_cnt          <= arm_cnt_n;
      Watchdog         <= (state_n == RUN);
      Watchdog_tripped <= (state_n == TRIPPED);
      if (trip_inc && Trip_count != 8'hFF) begin
        Trip_count <= Trip_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ebs_watchdog.sv
// Self-checking bench for ebs_watchdog (TIMEOUT_CYCLES=100, MIN_PERIOD=10,
// ARM_EDGES=3). The reference model works on gaps between detected beats.
// A beat is detected three clocks after the pin changes. The model pushes
// the expected outputs for each clock into a queue, and a monitor compares
// them against the DUT on the falling edge.
module tb_ebs_watchdog;

  localparam int T_CYC   = 100;
  localparam int MIN_P   = 10;
  localparam int ARM_N   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hb = 1'b0;
  logic       rearm = 1'b0;
  logic       wd;
  logic       wd_tr;
  logic [7:0] tcount;

  ebs_watchdog #(
    .TIMEOUT_CYCLES(T_CYC),
    .MIN_PERIOD    (MIN_P),
    .ARM_EDGES     (ARM_N)
  ) dut (
    .Clock           (clk),
    .Power_on_Reset  (rst),
    .Heartbeat       (hb),
    .Rearm           (rearm),
    .Watchdog        (wd),
    .Watchdog_tripped(wd_tr),
    .Trip_count      (tcount)
  );

  always #5 clk = ~clk;

  typedef enum int {M_ARM, M_RUN, M_TRIP} mode_t;
  typedef struct packed {
    logic       wd;
    logic       tr;
    logic [7:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    det_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model state. ref_n is the clock index from which the current
  // gap is measured: the last beat or the last state entry.
  mode_t mode;
  int    n;
  int    ref_n;
  int    arm;
  int    trips;

  // Stimulus controls.
  bit    tog_en;
  bit    rand_period;
  int    period;
  int    last_tog;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  // Monitor: compare each clock's expected outputs once they have settled.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("watchdog", {7'd0, wd}, {7'd0, e.wd});
      check("tripped", {7'd0, wd_tr}, {7'd0, e.tr});
      check("trip_count", tcount, e.cnt);
    end
  end

  // Advance one clock and apply the behavioural rules, then drive the next inputs.
  task automatic step();
    bit e;
    int gap;
    @(posedge clk);
    n++;
    e = (det_q.size() > 0 && det_q[0] == n);
    if (e) void'(det_q.pop_front());
    gap = n - ref_n;
    case (mode)
      M_ARM: begin
        if (gap > T_CYC) begin
          arm = 0;                       // window missed, arming restarts
          if (e) ref_n = n;
        end else if (e) begin
          arm++;
          ref_n = n;
          if (arm == ARM_N) begin
            mode = M_RUN;
            arm = 0;
          end
        end
      end
      M_RUN: begin
        if (e) begin
`ifdef EBS_WDG_MIN_PERIOD_CHECK_EN
          if (gap < MIN_P) begin
            mode = M_TRIP;
            trips = (trips < 255) ? trips + 1 : 255;
          end
`endif
          ref_n = n;
        end else if (gap == T_CYC) begin
          mode = M_TRIP;
          trips = (trips < 255) ? trips + 1 : 255;
          ref_n = n;
        end
      end
      default: begin
        if (rearm) begin
          mode = M_ARM;
          arm = 0;
          ref_n = n;
        end
      end
    endcase
    sb.push_back('{wd: (mode == M_RUN), tr: (mode == M_TRIP), cnt: trips[7:0]});
    #1;
    if (tog_en && (n - last_tog) >= period) begin
      hb = ~hb;
      last_tog = n;
      det_q.push_back(n + 3);
      if (rand_period) period = $urandom_range(3, 110);
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic start_toggle(input int p);
    period = p;
    last_tog = n;
    tog_en = 1'b1;
  endtask

  task automatic pulse_rearm(input int len);
    rearm = 1'b1;
    steps(len);
    rearm = 1'b0;
  endtask

  task automatic run_until(input mode_t target, input int budget, input string what);
    int k;
    k = 0;
    while (mode != target && k < budget) begin
      step();
      k++;
    end
    if (mode != target) begin
      tests++;
      fails++;
      $display("FAIL %s: target state not reached within %0d cycles", what, budget);
    end
  endtask

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    hb = 1'b0;
    rearm = 1'b0;
    tog_en = 1'b0;
    #1;
    check("rst_watchdog", {7'd0, wd}, 8'd0);
    check("rst_tripped", {7'd0, wd_tr}, 8'd0);
    check("rst_trip_count", tcount, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mode = M_ARM;
    n = 0;
    ref_n = 0;
    arm = 0;
    trips = 0;
    det_q.delete();
    rand_period = 1'b0;
  endtask

  initial begin
    // 1: arm with a 50-cycle heartbeat and stay healthy for 2000 cycles.
    do_reset();
    start_toggle(50);
    steps(2200);
    // 2: heartbeat stops; trip 100 cycles after the last beat.
    tog_en = 1'b0;
    steps(150);
    // 3: heartbeat resumes and Rearm pulses once; re-arm after 3 beats.
    start_toggle(50);
    steps(20);
    pulse_rearm(1);
    steps(300);
    // 4: 5-cycle heartbeat in RUN (a trip only with the min-period check).
    period = 5;
    steps(100);
    period = 50;
    steps(10);
    pulse_rearm(3);                      // held across the exit from TRIPPED
    run_until(M_RUN, 400, "rearm_after_fast");
    // 5: beats land exactly on the last legal cycle, 10+ times.
    period = 100;
    steps(1150);
    // Randomized heartbeat periods with random Rearm activity.
    rand_period = 1'b1;
    period = $urandom_range(3, 110);
    for (int i = 0; i < 5000; i++) begin
      rearm = ($urandom_range(0, 24) == 0);
      step();
    end
    rearm = 1'b0;
    rand_period = 1'b0;
    // 6: reach Trip_count = 2, then reset asynchronously mid-RUN.
    do_reset();
    for (int t = 0; t < 2; t++) begin
      start_toggle(50);
      run_until(M_RUN, 400, "arm_for_trip");
      tog_en = 1'b0;
      run_until(M_TRIP, 300, "trip");
      pulse_rearm(1);
    end
    start_toggle(50);
    run_until(M_RUN, 400, "arm_before_reset");
    steps(30);
    do_reset();
    start_toggle(50);
    steps(500);
    // Trip_count saturation: 256 quick arm/trip cycles.
    for (int t = 0; t < 256; t++) begin
      start_toggle(3);
      run_until(M_RUN, 200, "sat_arm");
      tog_en = 1'b0;
      run_until(M_TRIP, 300, "sat_trip");
      pulse_rearm(1);
    end
    steps(5);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
